ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
- Background scrubber for a SECDED-protected 39-bit memory (32 data + 7 check bits).
- Walks the array address by address and reads each word through an internal rvecc_decode.
- Writes corrected data back on a single-bit error. Logs double-bit errors without writing.
- Shares the memory port with the functional path through a req/gnt handshake; functional traffic always wins.

Parameters:
- DEPTH, 1024, number of 39-bit words scrubbed; legal range 2..65536.
- AW, $clog2(DEPTH), address width.
- INTERVAL, 256, idle cycles between successive word scrubs; legal range 1..65535.

Ports:
- clk  in  1  clock
- rst_l  in  1  synchronous active-low reset
- scrub_en  in  1  enables scrubbing; sampled in IDLE only
- clr_stats  in  1  pulse; clears counters, ded_flag and ded_addr
- mem_req  out  1  scrubber requests memory port
- mem_gnt  in  1  port granted this cycle
- mem_we  out  1  1 = write-back, 0 = read; valid while mem_req is high
- mem_addr  out  AW  word address
- mem_wdata  out  39  corrected word, {ecc[6:0], data[31:0]}
- mem_rdata  in  39  read data, valid the cycle after a granted read
- sec_count  out  16  corrected single-error count; saturates at 16'hFFFF
- ded_count  out  16  double-error count; saturates at 16'hFFFF
- ded_flag  out  1  sticky; set on the first DED since last clear
- ded_addr  out  AW  address of the first DED since last clear
- pass_done  out  1  one-cycle pulse after the last address completes
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_l, sampled on the rising clk edge).
- Reset values: all outputs 0; state IDLE; address pointer 0; interval counter INTERVAL-1.
- A mid-operation reset drops mem_req at that edge and abandons the current word; no partial write-back occurs.
- FSM states: IDLE -> RD_REQ -> RD_WAIT -> CHECK -> {WR_REQ | NEXT} -> NEXT -> IDLE.
- IDLE: with scrub_en=1, the interval counter decrements each cycle. When it reaches 0, go to RD_REQ. With scrub_en=0, the counter holds.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=ptr. Hold all three stable until mem_gnt=1, then go to RD_WAIT. Grant may be withheld indefinitely.
- RD_WAIT: register mem_rdata, then go to CHECK. Grant-to-register latency is exactly 1 cycle.
- CHECK: the registered word feeds rvecc_decode with en=1 and sed_ded=0 (correct mode).
  - No error: go to NEXT.
  - single_ecc_error: sec_count+1, mem_wdata <= {ecc_out, dout}, go to WR_REQ.
  - double_ecc_error: ded_count+1. If ded_flag=0, set ded_flag and latch ded_addr=ptr. No write-back. Go to NEXT.
- WR_REQ: mem_req=1, mem_we=1, mem_addr=ptr, mem_wdata stable until mem_gnt. On grant go to NEXT.
- Read-modify-write hazard: the functional path may write the same address between the scrub read and the write-back. The system arbiter prevents this by not granting functional writes while busy=1 and mem_addr matches. This is documented as an integration requirement, not checked inside the block.
- NEXT: if ptr==DEPTH-1, ptr wraps to 0 and pass_done pulses for 1 cycle; otherwise ptr+1. Reload the interval counter to INTERVAL-1 and return to IDLE.
- Deasserting scrub_en mid-word does not abort: the current word completes, then the FSM parks in IDLE.
- Counters: increment by 1 and saturate, never wrap.
- clr_stats in the same cycle as an increment: clear wins, so the count is 0 afterwards.
- clr_stats does not affect ptr or the FSM.
- Worst-case latency per word with immediate grants: INTERVAL + 5 cycles. Read grant at cycle t means write-back is requested at t+3.

Optional Feature:
- Macro: ECC_SCRUB_DED_HALT_EN.
- Defined: a DED moves CHECK to a HALT state instead of NEXT. HALT holds busy=1, mem_req=0 and ptr frozen. It exits to NEXT only on clr_stats.
- Not defined: there is no HALT state and a DED proceeds to NEXT as described above.

Decomposition:
- Package ecc_scrub_pkg holds:
  - scrub_state_e enum (IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, HALT);
  - ECC_W=7, DATA_W=32 and CW_W=39 constants;
  - CNT_W=16.
- The natural sub-module is ecc_sat_counter (width param, inc, clr with priority, saturate), instantiated twice.
- The decoder reuses the existing rvecc_decode.

Test Plan:
- Clean array, DEPTH=4, INTERVAL=2, gnt always 1 -> four reads with no writes; pass_done pulses once after address 3; ptr returns to 0; both counters stay 0.
- Address 2 holds an encoded word for 32'hDEADBEEF with data bit 5 flipped -> WR_REQ to addr 2 with mem_wdata = the original codeword; sec_count=1; ded_count=0.
- Address 1 has bits 0 and 38 flipped, then address 3 has bits 4 and 9 flipped -> ded_count=2, ded_flag=1, ded_addr=1, no writes; ECC_SCRUB_DED_HALT_EN build halts at addr 1 until clr_stats.
- Hold mem_gnt=0 for 10 cycles in RD_REQ -> mem_req, mem_we and mem_addr stable all 10 cycles; rdata is sampled only 1 cycle after the grant.
- Preload sec_count to 16'hFFFE, then inject 3 single errors -> count stays 16'hFFFF. clr_stats coincident with an SEC -> sec_count=0.
- Assert rst_l=0 while in WR_REQ -> mem_req=0 at the next edge; all outputs 0; on release, scrubbing restarts at addr 0 after INTERVAL cycles.

Source files
------------

// File: rtl/ecc_scrub_pkg.sv
// Shared types and constants for the ECC scrubber: FSM states, codeword widths,
// and the mapping between stored {ecc, data} layout and Hamming bit positions.
package ecc_scrub_pkg;
  localparam int ECC_W  = 7;
  localparam int DATA_W = 32;
  localparam int CW_W   = 39;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, HALT
  } scrub_state_e;

  // Hamming order: position 0 holds overall parity (ecc[6]), positions
  // 1,2,4,8,16,32 hold ecc[5:0], the rest hold data bits in ascending order.
  function automatic logic [CW_W-1:0] to_ham(input logic [DATA_W-1:0] d,
                                             input logic [ECC_W-1:0] e);
    logic [CW_W-1:0] h;
    int k;
    h = '0;
    k = 0;
    h[0]  = e[6];
    h[1]  = e[0];
    h[2]  = e[1];
    h[4]  = e[2];
    h[8]  = e[3];
    h[16] = e[4];
    h[32] = e[5];
    for (int p = 3; p < CW_W; p++) begin
      if (p != 4 && p != 8 && p != 16 && p != 32) begin
        h[p] = d[k[4:0]];
        k++;
      end
    end
    return h;
  endfunction

  function automatic logic [CW_W-1:0] from_ham(input logic [CW_W-1:0] h);
    logic [CW_W-1:0] cw;
    int k;
    cw = '0;
    k  = 0;
    cw[38] = h[0];
    cw[32] = h[1];
    cw[33] = h[2];
    cw[34] = h[4];
    cw[35] = h[8];
    cw[36] = h[16];
    cw[37] = h[32];
    for (int p = 3; p < CW_W; p++) begin
      if (p != 4 && p != 8 && p != 16 && p != 32) begin
        cw[k[4:0]] = h[p];
        k++;
      end
    end
    return cw;
  endfunction
endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module ecc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!rst_l)                     count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && count != '1)    count <= count + 1'b1;
  end
endmodule

// File: rtl/rvecc_decode.sv
// SECDED decoder for a 32-bit word with 7 check bits; corrects single errors
// (unless sed_ded=1) and flags double errors.
module rvecc_decode
  import ecc_scrub_pkg::*;
(
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [ECC_W-1:0]  ecc_in,
  input  logic              sed_ded,
  output logic [DATA_W-1:0] dout,
  output logic [ECC_W-1:0]  ecc_out,
  output logic              single_ecc_error,
  output logic              double_ecc_error
);
  logic [CW_W-1:0] h;
  logic [CW_W-1:0] hc;
  logic [5:0]      syn;
  logic            par;
  logic            fix;

  always_comb begin
    h   = to_ham(din, ecc_in);
    syn = '0;
    for (int p = 1; p < CW_W; p++) begin
      if (h[p]) syn = syn ^ 6'(p);
    end
    par = ^h;
    single_ecc_error = en & par;
    double_ecc_error = en & ~par & (syn != '0);
    fix = single_ecc_error & ~sed_ded;
    // A zero syndrome with bad parity means the parity bit itself flipped.
    hc = h;
    for (int p = 0; p < CW_W; p++) begin
      if (fix && syn == 6'(p)) hc[p] = ~hc[p];
    end
    {ecc_out, dout} = from_ham(hc);
  end
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: reads each word, writes back corrected data on SEC,
// logs DED. Define ECC_SCRUB_DED_HALT_EN to park in HALT on a DED until clr_stats.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int AW       = $clog2(DEPTH),
  parameter int INTERVAL = 256
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scrub_en,
  input  logic              clr_stats,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              ded_flag,
  output logic [AW-1:0]     ded_addr,
  output logic              pass_done,
  output logic              busy,
  output scrub_state_e      state_dbg
);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [15:0]   IVL_RELOAD = 16'(INTERVAL - 1);

  scrub_state_e      state;
  logic [AW-1:0]     ptr;
  logic [15:0]       ivl_cnt;
  logic [CW_W-1:0]   rdata_q;
  logic [DATA_W-1:0] dec_data;
  logic [ECC_W-1:0]  dec_ecc;
  logic              sec, ded, sec_inc, ded_inc;

  rvecc_decode u_dec (
    .en               (1'b1),
    .din              (rdata_q[DATA_W-1:0]),
    .ecc_in           (rdata_q[CW_W-1:DATA_W]),
    .sed_ded          (1'b0),
    .dout             (dec_data),
    .ecc_out          (dec_ecc),
    .single_ecc_error (sec),
    .double_ecc_error (ded)
  );

  assign sec_inc = (state == CHECK) & sec;
  assign ded_inc = (state == CHECK) & ded;

  ecc_sat_counter #(.W(CNT_W)) u_sec_cnt (
    .clk(clk), .rst_l(rst_l), .clr(clr_stats), .inc(sec_inc), .count(sec_count)
  );
  ecc_sat_counter #(.W(CNT_W)) u_ded_cnt (
    .clk(clk), .rst_l(rst_l), .clr(clr_stats), .inc(ded_inc), .count(ded_count)
  );

  // Memory port handshake: mem_req acts as valid; mem_we/mem_addr/mem_wdata are
  // held stable while mem_req=1, and the transfer happens in the cycle where
  // mem_req=1 and mem_gnt=1. Read data arrives exactly one cycle after that.
  assign mem_req   = (state == RD_REQ) || (state == WR_REQ);
  assign mem_we    = (state == WR_REQ);
  assign mem_addr  = ptr;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= IDLE;
      ptr       <= '0;
      ivl_cnt   <= IVL_RELOAD;
      rdata_q   <= '0;
      mem_wdata <= '0;
      pass_done <= 1'b0;
      ded_flag  <= 1'b0;
      ded_addr  <= '0;
    end else begin
      pass_done <= 1'b0;
      if (clr_stats) begin
        ded_flag <= 1'b0;
        ded_addr <= '0;
      end else if (ded_inc && !ded_flag) begin
        ded_flag <= 1'b1;
        ded_addr <= ptr;
      end
      case (state)
        IDLE: if (scrub_en) begin
          if (ivl_cnt == '0) state <= RD_REQ;
          else               ivl_cnt <= ivl_cnt - 1'b1;
        end
        RD_REQ: if (mem_gnt) state <= RD_WAIT;
        RD_WAIT: begin
          rdata_q <= mem_rdata;
          state   <= CHECK;
        end
        CHECK: begin
          if (sec) begin
            mem_wdata <= {dec_ecc, dec_data};
            state     <= WR_REQ;
          end else if (ded) begin
`ifdef ECC_SCRUB_DED_HALT_EN
            state <= HALT;
`else
            state <= NEXT;
`endif
          end else begin
            state <= NEXT;
          end
        end
        WR_REQ: if (mem_gnt) state <= NEXT;
        NEXT: begin
          if (ptr == LAST_ADDR) begin
            ptr       <= '0;
            pass_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
          ivl_cnt <= IVL_RELOAD;
          state   <= IDLE;
        end
`ifdef ECC_SCRUB_DED_HALT_EN
        HALT: if (clr_stats) state <= NEXT;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scoreboard bench for ecc_scrub_ctrl: memory model, expected access queue,
// directed error-injection vectors and a final report.
module tb_ecc_scrub_ctrl;
  import ecc_scrub_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int INTERVAL = 2;

  logic clk = 1'b0, rst_l = 1'b0, scrub_en = 1'b0, clr_stats = 1'b0;
  logic mem_req, mem_gnt, mem_we, ded_flag, pass_done, busy;
  logic [AW-1:0] mem_addr, ded_addr;
  logic [CW_W-1:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0] sec_count, ded_count;
  scrub_state_e state_dbg;

  logic gnt_rd = 1'b1, gnt_wr = 1'b1;
  logic sat_inc = 1'b0, sat_clr = 1'b0;
  logic [1:0] sat_count;

  logic [CW_W-1:0] mem [DEPTH];
  logic [31:0] data [DEPTH];
  logic [41:0] exp_q[$];
  logic [41:0] act_acc;
  int total = 0, bad = 0, pass_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  ecc_scrub_ctrl #(.DEPTH(DEPTH), .AW(AW), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst_l(rst_l), .scrub_en(scrub_en), .clr_stats(clr_stats),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .sec_count(sec_count),
    .ded_count(ded_count), .ded_flag(ded_flag), .ded_addr(ded_addr),
    .pass_done(pass_done), .busy(busy), .state_dbg(state_dbg)
  );

  ecc_sat_counter #(.W(2)) u_sat (
    .clk(clk), .rst_l(rst_l), .clr(sat_clr), .inc(sat_inc), .count(sat_count)
  );

  assign mem_gnt = mem_req & (mem_we ? gnt_wr : gnt_rd);

  // Read data only valid the cycle after a granted read; junk (odd parity) otherwise.
  always @(posedge clk)
    mem_rdata <= (mem_req && mem_gnt && !mem_we) ? mem[mem_addr] : '1;

  function automatic logic [CW_W-1:0] enc(input logic [31:0] d);
    logic [6:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int j = 0; j < 6; j++) if (p[j]) c[j] = c[j] ^ d[k[4:0]];
        k++;
      end
    end
    c[6] = (^d) ^ (^c[5:0]);
    return {c, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (pass_done) pass_cnt++;
    if (mem_req && mem_gnt) begin
      act_acc = {mem_we, mem_addr, mem_we ? mem_wdata : 39'h0};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_access: got %0h expected none", act_acc);
      end else begin
        chk("mem_access", act_acc, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input int a);
    exp_q.push_back({1'b0, 2'(a), 39'h0});
  endtask

  task automatic push_wr(input int a, input logic [CW_W-1:0] w);
    exp_q.push_back({1'b1, 2'(a), w});
  endtask

  task automatic push_pass_reads();
    for (int a = 0; a < DEPTH; a++) push_rd(a);
  endtask

  task automatic wait_pass(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (pass_done) begin
        seen = 1'b1;
        break;
      end
    end
    scrub_en = 1'b0;
    chk(name, seen, 1);
    tick(1);
    chk({name, "_q_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_state(input scrub_state_e s, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (state_dbg == s) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    chk(name, seen, 1);
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_sec_count"}, sec_count, 0);
    chk({tag, "_ded_count"}, ded_count, 0);
    chk({tag, "_ded_flag"}, ded_flag, 0);
    chk({tag, "_ded_addr"}, ded_addr, 0);
    chk({tag, "_pass_done"}, pass_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    data[0] = 32'h0000_0000;
    data[1] = 32'h1234_5678;
    data[2] = 32'hDEAD_BEEF;
    data[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < DEPTH; i++) mem[i] = enc(data[i]);

    tick(3);
    chk_all_zero("reset");
    rst_l = 1'b1;
    tick(1);

    // clean pass: four reads, no writes
    push_pass_reads();
    scrub_en = 1'b1;
    wait_pass("clean_pass");
    chk("clean_pass_cnt", pass_cnt, 1);
    chk("clean_sec", sec_count, 0);
    chk("clean_ded", ded_count, 0);
    chk("clean_busy", busy, 0);

    // single-bit error at addr 2 -> write-back of original codeword
    mem[2] = enc(data[2]) ^ (39'd1 << 5);
    push_rd(0); push_rd(1); push_rd(2);
    push_wr(2, enc(32'hDEAD_BEEF));
    push_rd(3);
    scrub_en = 1'b1;
    wait_pass("sec_pass");
    chk("sec_count_1", sec_count, 1);
    chk("sec_ded_0", ded_count, 0);
    mem[2] = enc(data[2]);

    // double-bit errors at addr 1 and addr 3
    pulse_clr();
    chk("clr_sec", sec_count, 0);
    mem[1] = enc(data[1]) ^ 39'd1 ^ (39'd1 << 38);
    mem[3] = enc(data[3]) ^ (39'd1 << 4) ^ (39'd1 << 9);
`ifdef ECC_SCRUB_DED_HALT_EN
    push_rd(0); push_rd(1);
    scrub_en = 1'b1;
    wait_state(HALT, "halt_at_1");
    tick(3);
    chk("halt_busy", busy, 1);
    chk("halt_req", mem_req, 0);
    chk("halt_ded_count", ded_count, 1);
    chk("halt_ded_addr", ded_addr, 1);
    push_rd(2); push_rd(3);
    pulse_clr();
    wait_state(HALT, "halt_at_3");
    chk("halt3_ded_count", ded_count, 1);
    chk("halt3_ded_addr", ded_addr, 3);
    pulse_clr();
    wait_pass("ded_pass");
    chk("halt_flag_cleared", ded_flag, 0);
`else
    push_pass_reads();
    scrub_en = 1'b1;
    wait_pass("ded_pass");
    chk("ded_count_2", ded_count, 2);
    chk("ded_flag_set", ded_flag, 1);
    chk("ded_addr_first", ded_addr, 1);
    chk("ded_sec_0", sec_count, 0);
`endif
    mem[1] = enc(data[1]);
    mem[3] = enc(data[3]);

    // grant withheld for 10 cycles in RD_REQ
    gnt_rd = 1'b0;
    push_pass_reads();
    scrub_en = 1'b1;
    wait_state(RD_REQ, "hold_reach_rdreq");
    for (int i = 0; i < 10; i++) begin
      chk("hold_req", mem_req, 1);
      chk("hold_we", mem_we, 0);
      chk("hold_addr", mem_addr, 0);
      chk("hold_state", state_dbg, RD_REQ);
      tick(1);
    end
    gnt_rd = 1'b1;
    wait_pass("hold_pass");
    chk("hold_sec_0", sec_count, 0);

    // clr_stats coincident with an SEC: clear wins
    mem[0] = enc(data[0]) ^ (39'd1 << 17);
    push_rd(0);
    push_wr(0, enc(data[0]));
    push_rd(1); push_rd(2); push_rd(3);
    scrub_en = 1'b1;
    wait_state(CHECK, "clr_reach_check");
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    chk("clr_vs_inc", sec_count, 0);
    wait_pass("clr_pass");
    chk("clr_sec_after", sec_count, 0);
    mem[0] = enc(data[0]);

    // saturation on a narrow counter instance: expected 1,2,3,3,3
    sat_inc = 1'b1;
    tick(1); chk("sat_1", sat_count, 2'd1);
    tick(1); chk("sat_2", sat_count, 2'd2);
    tick(1); chk("sat_3", sat_count, 2'd3);
    tick(1); chk("sat_hold_a", sat_count, 2'd3);
    tick(1); chk("sat_hold_b", sat_count, 2'd3);
    sat_clr = 1'b1;
    tick(1); chk("sat_clr_wins", sat_count, 2'd0);
    sat_clr = 1'b0;
    sat_inc = 1'b0;

    // reset while stalled in WR_REQ
    mem[2] = enc(data[2]) ^ (39'd1 << 30);
    gnt_wr = 1'b0;
    push_rd(0); push_rd(1); push_rd(2);
    scrub_en = 1'b1;
    wait_state(WR_REQ, "rst_reach_wrreq");
    chk("wr_req", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 2);
    chk("wr_wdata", mem_wdata, enc(data[2]));
    chk("wr_sec", sec_count, 1);
    rst_l = 1'b0;
    tick(1);
    chk_all_zero("midrst");
    rst_l = 1'b1;
    gnt_wr = 1'b1;
    push_rd(0); push_rd(1); push_rd(2);
    push_wr(2, enc(data[2]));
    push_rd(3);
    tick(1);
    chk("restart_idle", mem_req, 0);
    tick(1);
    chk("restart_req", mem_req, 1);
    chk("restart_addr", mem_addr, 0);
    wait_pass("rst_pass");
    chk("rst_sec", sec_count, 1);
    mem[2] = enc(data[2]);

    chk("total_passes", pass_cnt, 6);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
